// File: rtl/mf_pkg.sv
// mf_pkg: shared matched-filter widths and peak-detector state encoding
package mf_pkg;
    localparam int SAMPLE_W = 38;
    localparam int IDX_W    = 16;
    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_HOLDOFF} state_t;
endpackage

// File: rtl/mf_abs_sat.sv
// mf_abs_sat: combinational saturating magnitude (most-negative maps to max positive)
module mf_abs_sat
    import mf_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] y,
    output logic signed [SAMPLE_W-1:0] mag
);
    localparam logic signed [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    // negate negatives, clamp the one value whose negation overflows
    always_comb mag = (y == MIN_NEG) ? MAX_POS : ((y < 0) ? -y : y);
endmodule

// File: rtl/mf_peak_detector.sv
// mf_peak_detector: windowed peak search after threshold crossing, with hold-off (MF_PEAK_ABS_EN selects magnitude compare)
module mf_peak_detector
    import mf_pkg::*;
#(
    parameter int WIN_LEN     = 64,
    parameter int HOLDOFF_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       y_valid,
    input  logic signed [SAMPLE_W-1:0] y,
    input  logic signed [SAMPLE_W-1:0] threshold,
    input  logic                       clear,
    output logic                       peak_valid,
    output logic signed [SAMPLE_W-1:0] peak_value,
    output logic        [IDX_W-1:0]    peak_index,
    output logic                       detected,
    output logic                       busy
);
    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int HC_W = $clog2(HOLDOFF_LEN + 2);

    state_t                     state_q, state_d;
    logic        [IDX_W-1:0]    idx_q, idx_d, max_idx_q, max_idx_d, peak_index_q, peak_index_d;
    logic        [WC_W-1:0]     win_cnt_q, win_cnt_d;
    logic        [HC_W-1:0]     ho_cnt_q, ho_cnt_d;
    logic signed [SAMPLE_W-1:0] max_val_q, max_val_d, peak_value_q, peak_value_d;
    logic                       peak_valid_q, peak_valid_d, detected_q, detected_d, busy_q, busy_d;
    logic signed [SAMPLE_W-1:0] m, cand_val;
    logic        [IDX_W-1:0]    cand_idx;
    logic                       report;

`ifdef MF_PEAK_ABS_EN
    mf_abs_sat u_abs (.y(y), .mag(m));
`else
    assign m = y;
`endif

    assign peak_valid = peak_valid_q;
    assign peak_value = peak_value_q;
    assign peak_index = peak_index_q;
    assign detected   = detected_q;
    assign busy       = busy_q;

    // next-state: crossing detect, running max (earliest wins ties), window/hold-off counting
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        win_cnt_d    = win_cnt_q;
        ho_cnt_d     = ho_cnt_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        peak_value_d = peak_value_q;
        peak_index_d = peak_index_q;
        peak_valid_d = 1'b0;
        detected_d   = detected_q;
        report       = 1'b0;
        cand_val     = (state_q == S_TRACK && m <= max_val_q) ? max_val_q : m;
        cand_idx     = (state_q == S_TRACK && m <= max_val_q) ? max_idx_q : idx_q;
        if (clear) begin
            state_d      = S_SEARCH;
            idx_d        = '0;
            win_cnt_d    = '0;
            ho_cnt_d     = '0;
            max_val_d    = '0;
            max_idx_d    = '0;
            peak_value_d = '0;
            peak_index_d = '0;
            detected_d   = 1'b0;
        end else if (y_valid) begin
            idx_d = idx_q + 1'b1;
            case (state_q)
                S_SEARCH: if (m >= threshold) begin
                    state_d   = S_TRACK;
                    max_val_d = m;
                    max_idx_d = idx_q;
                    win_cnt_d = WC_W'(1);
                    report    = (WIN_LEN == 1);
                end
                S_TRACK: begin
                    max_val_d = cand_val;
                    max_idx_d = cand_idx;
                    win_cnt_d = win_cnt_q + 1'b1;
                    report    = (win_cnt_q == WC_W'(WIN_LEN - 1));
                end
                S_HOLDOFF: begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                    if (ho_cnt_q == HC_W'(HOLDOFF_LEN - 1)) state_d = S_SEARCH;
                end
                default: state_d = S_SEARCH;
            endcase
            if (report) begin
                peak_value_d = cand_val;
                peak_index_d = cand_idx;
                peak_valid_d = 1'b1;
                detected_d   = 1'b1;
                win_cnt_d    = '0;
                ho_cnt_d     = '0;
                state_d      = (HOLDOFF_LEN == 0) ? S_SEARCH : S_HOLDOFF;
            end
        end
        busy_d = (state_d != S_SEARCH);
    end

    // state and output registers, async reset aborts any event in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SEARCH;
            idx_q        <= '0;
            win_cnt_q    <= '0;
            ho_cnt_q     <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            peak_valid_q <= 1'b0;
            detected_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            win_cnt_q    <= win_cnt_d;
            ho_cnt_q     <= ho_cnt_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            peak_value_q <= peak_value_d;
            peak_index_q <= peak_index_d;
            peak_valid_q <= peak_valid_d;
            detected_q   <= detected_d;
            busy_q       <= busy_d;
        end
    end
endmodule

// File: tb/tb_mf_peak_detector.sv
// tb_mf_peak_detector: directed and random checks against a sample-history reference model
module tb_mf_peak_detector;
    import mf_pkg::*;
    localparam int WIN = 4;
    localparam int HO  = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       y_valid = 1'b0;
    logic                       clear = 1'b0;
    logic signed [SAMPLE_W-1:0] y = '0;
    logic signed [SAMPLE_W-1:0] thr = 38'sd100;
    logic                       peak_valid, detected, busy;
    logic signed [SAMPLE_W-1:0] peak_value;
    logic        [IDX_W-1:0]    peak_index;

    int vectors = 0;
    int miscompares = 0;

    logic signed [SAMPLE_W-1:0] hist[$];
    int                         start, eligible;
    logic                       exp_pv, exp_det, exp_busy;
    logic signed [SAMPLE_W-1:0] exp_val;
    logic        [IDX_W-1:0]    exp_idx;

    mf_peak_detector #(.WIN_LEN(WIN), .HOLDOFF_LEN(HO)) dut (
        .clk(clk), .rst(rst), .y_valid(y_valid), .y(y), .threshold(thr), .clear(clear),
        .peak_valid(peak_valid), .peak_value(peak_value), .peak_index(peak_index),
        .detected(detected), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [SAMPLE_W-1:0] mag(input logic signed [SAMPLE_W-1:0] s);
`ifdef MF_PEAK_ABS_EN
        longint a = s;
        longint lim = (64'sd1 <<< (SAMPLE_W - 1)) - 1;
        if (a < 0) a = -a;
        if (a > lim) a = lim;
        return SAMPLE_W'(a);
`else
        return s;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        start = -1;
        eligible = 0;
        exp_pv = 0;
        exp_det = 0;
        exp_busy = 0;
        exp_val = '0;
        exp_idx = '0;
    endtask

    // reference: keep every accepted sample; an event is a crossing at an eligible position,
    // its report is the earliest maximum over the next WIN positions
    task automatic model(input bit v, input bit c, input logic signed [SAMPLE_W-1:0] s);
        int p, best;
        exp_pv = 0;
        if (c) model_reset();
        else if (v) begin
            hist.push_back(s);
            p = hist.size() - 1;
            if (start < 0 && p >= eligible && mag(s) >= thr) start = p;
            if (start >= 0 && p == start + WIN - 1) begin
                best = start;
                for (int q = start + 1; q <= p; q++)
                    if (mag(hist[q]) > mag(hist[best])) best = q;
                exp_val = mag(hist[best]);
                exp_idx = IDX_W'(best);
                exp_pv = 1;
                exp_det = 1;
                eligible = p + 1 + HO;
                start = -1;
            end
        end
        exp_busy = (start >= 0) || (hist.size() < eligible);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("peak_valid", 64'(peak_valid), 64'(exp_pv));
        chk("peak_value", 64'(peak_value), 64'(exp_val));
        chk("peak_index", 64'(peak_index), 64'(exp_idx));
        chk("detected", 64'(detected), 64'(exp_det));
        chk("busy", 64'(busy), 64'(exp_busy));
    endtask

    task automatic step(input bit v, input bit c, input logic signed [SAMPLE_W-1:0] s);
        @(negedge clk);
        y_valid = v;
        clear = c;
        y = s;
        @(posedge clk);
        #1;
        model(v, c, s);
        check_all();
    endtask

    initial begin
        logic signed [SAMPLE_W-1:0] rs;
        logic signed [SAMPLE_W-1:0] minneg;
        bit rv, rc;
        minneg = {1'b1, {(SAMPLE_W-1){1'b0}}};
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        // test 1: async reset mid-event
        step(1, 0, 38'sd200);
        step(1, 0, 38'sd50);
        chk("t1_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        y_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        // test 2: first event after reset, index restarts at 0
        step(1, 0, 38'sd5);
        step(1, 0, 38'sd120);
        step(0, 0, 38'sd999);
        step(1, 0, 38'sd90);
        step(1, 0, 38'sd300);
        step(1, 0, 38'sd7);
        chk("t2_pv", 64'(peak_valid), 64'd1);
        chk("t2_val", 64'(peak_value), 64'(38'sd300));
        chk("t2_idx", 64'(peak_index), 64'd3);
        chk("t2_det", 64'(detected), 64'd1);
        step(1, 0, 38'sd8);
        chk("t2_pulse_end", 64'(peak_valid), 64'd0);
        step(1, 0, 38'sd9);
        chk("t2_holdoff_done", 64'(busy), 64'd0);
        // test 3: ties keep earliest
        step(0, 1, 38'sd0);
        for (int i = 0; i < 4; i++) step(1, 0, 38'sd150);
        chk("t3_val", 64'(peak_value), 64'(38'sd150));
        chk("t3_idx", 64'(peak_index), 64'd0);
        // test 4: hold-off samples ignored
        step(1, 0, 38'sd500);
        step(1, 0, 38'sd500);
        step(1, 0, 38'sd200);
        chk("t4_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) step(1, 0, 38'sd10);
        chk("t4_val", 64'(peak_value), 64'(38'sd200));
        chk("t4_idx", 64'(peak_index), 64'd6);
        step(1, 0, 38'sd0);
        step(1, 0, 38'sd0);
        // test 5: negative threshold and magnitude mode
        step(0, 1, 38'sd0);
        thr = -38'sd300;
        step(1, 0, -38'sd200);
        chk("t5_cross", 64'(busy), 64'd1);
        step(1, 0, -38'sd250);
        step(1, 0, -38'sd100);
        step(1, 0, -38'sd400);
        step(1, 0, 38'sd0);
        step(1, 0, 38'sd0);
        step(0, 1, 38'sd0);
        thr = 38'sd100;
        step(1, 0, -38'sd200);
        for (int i = 0; i < 3; i++) step(1, 0, 38'sd0);
`ifdef MF_PEAK_ABS_EN
        chk("t5_abs_val", 64'(peak_value), 64'(38'sd200));
`endif
        step(1, 0, 38'sd0);
        step(1, 0, 38'sd0);
        // test 6: clear with y_valid mid-track
        step(0, 1, 38'sd0);
        step(1, 0, 38'sd150);
        step(1, 0, 38'sd10);
        step(1, 1, 38'sd999);
        chk("t6_det", 64'(detected), 64'd0);
        step(1, 0, 38'sd150);
        for (int i = 0; i < 3; i++) step(1, 0, 38'sd1);
        chk("t6_idx", 64'(peak_index), 64'd0);
        // random traffic including saturation corner
        for (int i = 0; i < 500; i++) begin
            if (!exp_busy && $urandom_range(0, 9) == 0)
                thr = SAMPLE_W'(int'($urandom_range(0, 500)) - 200);
            rv = ($urandom_range(0, 9) < 7);
            rc = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0: rs = SAMPLE_W'({$urandom, $urandom});
                1: rs = minneg;
                default: rs = SAMPLE_W'(int'($urandom_range(0, 800)) - 400);
            endcase
            step(rv, rc, rs);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
